// File: rtl/reset_ctrl_pkg.sv
// Shared constants for the reset controller: register map, cause bit
// positions, software-reset key, FSM state encoding.
package reset_ctrl_pkg;

  localparam logic [1:0] ADDR_CAUSE = 2'd0;
  localparam logic [1:0] ADDR_SWRST = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;

  localparam int unsigned CAUSE_POR = 0;
  localparam int unsigned CAUSE_WDT = 1;
  localparam int unsigned CAUSE_EXT = 2;
  localparam int unsigned CAUSE_SW  = 3;
  localparam int unsigned CAUSE_W   = 4;

  localparam logic [7:0] SWRST_KEY = 8'hA5;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Saturating 8-bit increment used by the reset-event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rst_sync_debounce.sv
// Push-button conditioning: 2-flop synchronizer followed by a debounce
// counter. req rises after DEBOUNCE_CYCLES consecutive synced-low samples
// and drops on the first synced-high sample.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low power-on reset
//   in_n     asynchronous active-low button input
//   req      registered, debounced reset request (active-high)
module rst_sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_n,
  output logic req
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] cnt;

  // Synchronizer flops idle high so a released button is seen at reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      req   <= 1'b0;
    end else begin
      sync1 <= in_n;
      sync2 <= sync1;
      if (sync2) begin
        cnt <= '0;
        req <= 1'b0;
      end else if (cnt == LAST) begin
        // cnt holds at LAST while the button stays down.
        req <= 1'b1;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_ctrl.sv
// System reset controller: merges watchdog, push-button and software reset
// requests into a stretched sys_reset_n, and keeps a reset-cause register
// plus saturating event counter that only power-on reset clears.
// Ports:
//   clk, reset_n          clock, synchronous active-low power-on reset
//   wdt_reset             watchdog request (active-high level)
//   ext_rst_n             asynchronous push-button (active-low)
//   sys_reset_n           registered system reset (active-low)
//   cs_n, rd_n, wr_n      bus strobes (active-low)
//   addr, data_in         register select and write data
//   data_out              combinational read data, 8'h00 when not selected
module reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int unsigned STRETCH_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wdt_reset,
  input  logic       ext_rst_n,
  output logic       sys_reset_n,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] addr
);

  localparam int unsigned CNT_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

  state_t             state;
  logic [CNT_W-1:0]   stretch_cnt;
  logic [CAUSE_W-1:0] cause;
  logic [7:0]         count;

  logic               ext_req;
  logic               write_sel;
  logic               read_sel;
  logic               run_wr;
  logic               sw_req;
  logic               any_src;
  logic               trig;
  logic [CAUSE_W-1:0] cause_set;
  logic [CAUSE_W-1:0] cause_clr;

  rst_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ext (
    .clk    (clk),
    .reset_n(reset_n),
    .in_n   (ext_rst_n),
    .req    (ext_req)
  );

  // Bus decode; writes only land while the system is running.
  always_comb begin
    write_sel = !cs_n && rd_n && !wr_n;
    read_sel  = !cs_n && !rd_n && wr_n;
    run_wr    = write_sel && (state == ST_RUN);
    sw_req    = run_wr && (addr == ADDR_SWRST) && (data_in == SWRST_KEY);
    any_src   = wdt_reset || ext_req;
    trig      = (state == ST_RUN) && (wdt_reset || ext_req || sw_req);
  end

  // Cause bits captured on the RUN -> HOLD edge; W1C from the bus.
  always_comb begin
    cause_set            = '0;
    cause_set[CAUSE_WDT] = trig && wdt_reset;
    cause_set[CAUSE_EXT] = trig && ext_req;
    cause_set[CAUSE_SW]  = trig && sw_req;
    cause_clr            = '0;
    if (run_wr && (addr == ADDR_CAUSE)) begin
      cause_clr = data_in[CAUSE_W-1:0];
    end
  end

  // Reset sequencer: HOLD while any source is active, then stretch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_HOLD;
      sys_reset_n <= 1'b0;
      stretch_cnt <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!any_src) begin
            state       <= ST_STRETCH;
            stretch_cnt <= '0;
          end
        end
        ST_STRETCH: begin
          if (any_src) begin
            state       <= ST_HOLD;
            stretch_cnt <= '0;
          end else if (stretch_cnt == STRETCH_LAST) begin
            state       <= ST_RUN;
            sys_reset_n <= 1'b1;
          end else begin
            stretch_cnt <= stretch_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (trig) begin
            state       <= ST_HOLD;
            sys_reset_n <= 1'b0;
          end
        end
        default: begin
          state       <= ST_HOLD;
          sys_reset_n <= 1'b0;
          stretch_cnt <= '0;
        end
      endcase
    end
  end

  // Cause and event counter; set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cause            <= '0;
      cause[CAUSE_POR] <= 1'b1;
      count            <= 8'h00;
    end else begin
      cause <= (cause & ~cause_clr) | cause_set;
      if (trig) begin
        count <= sat_inc8(count);
      end else if (run_wr && (addr == ADDR_COUNT)) begin
        count <= 8'h00;
      end
    end
  end

  // Read mux.
  always_comb begin
    data_out = 8'h00;
    if (read_sel) begin
      case (addr)
        ADDR_CAUSE: data_out = 8'(cause);
        ADDR_COUNT: data_out = count;
        default:    data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl: stimulus pushes expected read data and
// expected sys_reset_n edge windows; a monitor compares on every read and
// on every sys_reset_n transition.
module tb_reset_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wdt_reset;
  logic       ext_rst_n;
  logic       sys_reset_n;
  logic [7:0] data_out;
  logic [7:0] data_in;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic [1:0] addr;

  typedef struct {
    string      name;
    logic [7:0] val;
  } rd_exp_t;

  typedef struct {
    string name;
    int    lo;
    int    hi;
  } win_t;

  rd_exp_t rdq[$];
  win_t    fallq[$];
  win_t    riseq[$];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic mon_rd = 1'b0;
  logic prev_srn = 1'b0;

  reset_ctrl #(
    .STRETCH_CYCLES (16),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wdt_reset  (wdt_reset),
    .ext_rst_n  (ext_rst_n),
    .sys_reset_n(sys_reset_n),
    .data_out   (data_out),
    .data_in    (data_in),
    .cs_n       (cs_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .addr       (addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reads and sys_reset_n edges, sampled on the falling edge.
  always @(negedge clk) begin
    rd_exp_t e;
    win_t    w;
    if (mon_rd) begin
      n_cmp++;
      if (rdq.size() == 0) begin
        n_bad++;
        $display("FAIL rd_underflow: read at cycle %0d with nothing expected", cyc);
      end else begin
        e = rdq.pop_front();
        if (data_out !== e.val) begin
          n_bad++;
          $display("FAIL %s: data_out=%02h required %02h (cycle %0d)", e.name, data_out, e.val, cyc);
        end
      end
    end
    if (prev_srn === 1'b1 && sys_reset_n === 1'b0) begin
      n_cmp++;
      if (fallq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_fall: sys_reset_n fell at cycle %0d, required no reset", cyc);
      end else begin
        w = fallq.pop_front();
        if (cyc < w.lo || cyc > w.hi) begin
          n_bad++;
          $display("FAIL %s_fall: cycle %0d required %0d..%0d", w.name, cyc, w.lo, w.hi);
        end
      end
    end
    if (prev_srn === 1'b0 && sys_reset_n === 1'b1) begin
      n_cmp++;
      if (riseq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rise: sys_reset_n rose at cycle %0d", cyc);
      end else begin
        w = riseq.pop_front();
        if (cyc < w.lo || cyc > w.hi) begin
          n_bad++;
          $display("FAIL %s_rise: cycle %0d required %0d..%0d", w.name, cyc, w.lo, w.hi);
        end
      end
    end
    prev_srn = sys_reset_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic exp_fall(input string name, input int lo, input int hi);
    win_t w;
    w.name = name; w.lo = lo; w.hi = hi;
    fallq.push_back(w);
  endtask

  task automatic exp_rise(input string name, input int lo, input int hi);
    win_t w;
    w.name = name; w.lo = lo; w.hi = hi;
    riseq.push_back(w);
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [7:0] v);
    rd_exp_t e;
    e.name = name; e.val = v;
    rdq.push_back(e);
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; addr = a; mon_rd = 1'b1;
    tick();
    cs_n = 1'b1; rd_n = 1'b1; mon_rd = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    cs_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0; addr = a; data_in = v;
    tick();
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic wait_high(input string name);
    int n;
    n = 0;
    while (sys_reset_n !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_cmp++;
    if (sys_reset_n !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_timeout: sys_reset_n=%b after 200 cycles, required 1", name, sys_reset_n);
    end
  endtask

  // Hang guard.
  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset_n = 1'b0; wdt_reset = 1'b0; ext_rst_n = 1'b1;
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; addr = 2'd0; data_in = 8'h00;

    // Power-on: values during reset, then 1 HOLD + 16 STRETCH cycles.
    tick();
    rd("por_cause", 2'd0, 8'h01);
    rd("por_count", 2'd2, 8'h00);
    k = cyc;
    reset_n = 1'b1;
    exp_rise("por", k + 17, k + 17);
    wait_high("por");
    rd("por_cause_run", 2'd0, 8'h01);
    rd("por_count_run", 2'd2, 8'h00);

    // Watchdog held until one cycle after the fall.
    k = cyc;
    exp_fall("wdt", k + 1, k + 1);
    exp_rise("wdt", k + 19, k + 19);
    wdt_reset = 1'b1;
    run(2);
    wdt_reset = 1'b0;
    wait_high("wdt");
    rd("wdt_cause", 2'd0, 8'h03);
    rd("wdt_count", 2'd2, 8'h01);

    // Wrong key ignored, right key resets; W1C during reset is ignored.
    wr(2'd1, 8'h5A);
    run(5);
    k = cyc;
    exp_fall("sw", k + 1, k + 1);
    exp_rise("sw", k + 18, k + 18);
    wr(2'd1, 8'hA5);
    wr(2'd0, 8'h0F);
    wait_high("sw");
    rd("sw_cause", 2'd0, 8'h0B);
    rd("sw_count", 2'd2, 8'h02);
    wr(2'd0, 8'h0F);
    rd("w1c_cause", 2'd0, 8'h00);

    // Button: 7-cycle glitch rejected, 30-cycle press accepted.
    ext_rst_n = 1'b0;
    run(7);
    ext_rst_n = 1'b1;
    run(20);
    k = cyc;
    exp_fall("ext", k + 10, k + 11);
    exp_rise("ext", k + 46, k + 50);
    ext_rst_n = 1'b0;
    run(30);
    ext_rst_n = 1'b1;
    wait_high("ext");
    rd("ext_cause", 2'd0, 8'h04);
    rd("ext_count", 2'd2, 8'h03);

    // Watchdog and software key in the same cycle: one event, two bits.
    wr(2'd0, 8'h0F);
    k = cyc;
    exp_fall("simul", k + 1, k + 1);
    exp_rise("simul", k + 18, k + 18);
    wdt_reset = 1'b1;
    wr(2'd1, 8'hA5);
    wdt_reset = 1'b0;
    wait_high("simul");
    rd("simul_cause", 2'd0, 8'h0A);
    rd("simul_count", 2'd2, 8'h04);

    // Watchdog re-asserted mid-stretch restarts the full stretch.
    wr(2'd0, 8'h0F);
    k = cyc;
    exp_fall("reassert", k + 1, k + 1);
    exp_rise("reassert", k + 26, k + 26);
    wdt_reset = 1'b1;
    tick();
    wdt_reset = 1'b0;
    run(7);
    wdt_reset = 1'b1;
    tick();
    wdt_reset = 1'b0;
    wait_high("reassert");
    rd("reassert_cause", 2'd0, 8'h02);
    rd("reassert_count", 2'd2, 8'h05);

    // Counter saturation.
    for (int i = 0; i < 256; i++) begin
      k = cyc;
      exp_fall("sat", k + 1, k + 1);
      exp_rise("sat", k + 18, k + 18);
      wdt_reset = 1'b1;
      tick();
      wdt_reset = 1'b0;
      wait_high("sat");
    end
    rd("sat_count", 2'd2, 8'hFF);
    wr(2'd2, 8'h33);
    rd("count_clear", 2'd2, 8'h00);
    rd("addr3", 2'd3, 8'h00);

    // Not selected: data_out must be 0 even though CAUSE is non-zero.
    begin
      rd_exp_t e;
      e.name = "idle_bus"; e.val = 8'h00;
      rdq.push_back(e);
      cs_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1; addr = 2'd0; mon_rd = 1'b1;
      tick();
      rd_n = 1'b1; mon_rd = 1'b0;
    end
    rd("cause_before_por", 2'd0, 8'h02);

    // Power-on reset while running clears cause to POR and count to 0.
    k = cyc;
    exp_fall("por_run", k + 1, k + 1);
    reset_n = 1'b0;
    tick();
    rd("por_run_cause", 2'd0, 8'h01);
    rd("por_run_count", 2'd2, 8'h00);
    k = cyc;
    exp_rise("por_run", k + 17, k + 17);
    reset_n = 1'b1;
    wait_high("por_run");
    run(3);

    n_cmp++;
    if (rdq.size() != 0 || fallq.size() != 0 || riseq.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: rd=%0d fall=%0d rise=%0d outstanding, required 0",
               rdq.size(), fallq.size(), riseq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
